ram16_burst_master: RTL and testbench

- Word-level initiator for one ram16 bit-serial memory.
- Accepts a single 16-bit read or write request and turns it into a burst of single-bit ram16 accesses on the memory's address, write-enable and set pins.
- For reads, collects the ram16 result bit, which arrives one cycle after each address, and reassembles the word.
- Sits between the datapath/control logic and each ram16 bank, so upstream logic never drives ram16 pins directly.

---
 rtl/ram16_burst_master.sv | 155 +++++++++++++++
 tb/tb_ram16_burst_master.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram16_burst_master.sv
// Word-level initiator for one ram16 bit-serial memory: turns a 16-bit request into a burst of single-bit accesses.
// Optional macro RAM16_WRITE_VERIFY_EN adds a sticky verify_err output that compares write echoes against the sent bits.
module ram16_burst_master #(
  parameter int BURST_LEN = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        mem_we,
  output logic        mem_set,
  output logic        mem_a0,
  output logic        mem_a1,
  output logic        mem_a2,
  output logic        mem_a3,
`ifdef RAM16_WRITE_VERIFY_EN
  output logic        verify_err,
`endif
  input  logic        mem_result
);

  typedef enum logic [1:0] {IDLE, XFER, DRAIN} state_e;

  localparam logic [3:0] LAST = 4'(BURST_LEN - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        write_q, write_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] shift_q, shift_d;
  logic [15:0] rdata_q, rdata_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        ready_q, ready_d;
  logic        we_q, we_d;
  logic        set_q, set_d;
  logic [3:0]  addr_q, addr_d;
  logic        cap_en;
  logic [3:0]  cap_idx;
`ifdef RAM16_WRITE_VERIFY_EN
  logic        err_q, err_d;
`endif

  // mem_result lags the address by one cycle, so the bit arriving now belongs to the previous address.
  assign cap_en  = ((state_q == XFER) && (cnt_q != 4'd0)) || (state_q == DRAIN);
  assign cap_idx = (state_q == DRAIN) ? cnt_q : (cnt_q - 4'd1);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    write_d     = write_q;
    wdata_d     = wdata_q;
    shift_d     = shift_q;
    rdata_d     = rdata_q;
    rsp_valid_d = 1'b0;
    ready_d     = 1'b0;
    we_d        = 1'b0;
    set_d       = 1'b0;
    addr_d      = addr_q;
`ifdef RAM16_WRITE_VERIFY_EN
    err_d       = err_q;
    if (cap_en && write_q && (mem_result != wdata_q[cap_idx])) err_d = 1'b1;
`endif
    if (cap_en && !write_q) shift_d[cap_idx] = mem_result;

    case (state_q)
      IDLE: begin
        addr_d = 4'd0;
        if (req_valid && ready_q) begin
          state_d = XFER;
          cnt_d   = 4'd0;
          write_d = req_write;
          wdata_d = req_wdata;
          shift_d = 16'h0000;
          we_d    = req_write;
          set_d   = req_write & req_wdata[0];
`ifdef RAM16_WRITE_VERIFY_EN
          err_d   = 1'b0;
`endif
        end else begin
          ready_d = 1'b1;
        end
      end
      XFER: begin
        if (cnt_q == LAST) begin
          state_d = DRAIN;
        end else begin
          cnt_d  = cnt_q + 4'd1;
          addr_d = cnt_q + 4'd1;
          we_d   = write_q;
          set_d  = write_q & wdata_q[cnt_q + 4'd1];
        end
      end
      DRAIN: begin
        state_d     = IDLE;
        rsp_valid_d = 1'b1;
        ready_d     = 1'b1;
        addr_d      = 4'd0;
        if (!write_q) rdata_d = shift_d;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      write_q     <= 1'b0;
      wdata_q     <= 16'h0000;
      shift_q     <= 16'h0000;
      rdata_q     <= 16'h0000;
      rsp_valid_q <= 1'b0;
      ready_q     <= 1'b1;
      we_q        <= 1'b0;
      set_q       <= 1'b0;
      addr_q      <= 4'd0;
`ifdef RAM16_WRITE_VERIFY_EN
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      write_q     <= write_d;
      wdata_q     <= wdata_d;
      shift_q     <= shift_d;
      rdata_q     <= rdata_d;
      rsp_valid_q <= rsp_valid_d;
      ready_q     <= ready_d;
      we_q        <= we_d;
      set_q       <= set_d;
      addr_q      <= addr_d;
`ifdef RAM16_WRITE_VERIFY_EN
      err_q       <= err_d;
`endif
    end
  end

  assign req_ready = ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign mem_we    = we_q;
  assign mem_set   = set_q;
  assign mem_a0    = addr_q[3];
  assign mem_a1    = addr_q[2];
  assign mem_a2    = addr_q[1];
  assign mem_a3    = addr_q[0];
`ifdef RAM16_WRITE_VERIFY_EN
  assign verify_err = err_q;
`endif

endmodule

// File: tb/tb_ram16_burst_master.sv
// Bench for ram16_burst_master: a 16-bit and a 4-bit burst instance share one stimulus stream,
// each driving its own ram16 model, checked every cycle against a transaction-timeline model.
module tb_ram16_burst_master;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [15:0] req_wdata = 16'h0000;
  logic        forceZero = 1'b0;

  logic        rdy [2];
  logic        rspv [2];
  logic        we [2];
  logic        set [2];
  logic        a0 [2];
  logic        a1 [2];
  logic        a2 [2];
  logic        a3 [2];
  logic        memRes [2];
  logic [15:0] rdata [2];
`ifdef RAM16_WRITE_VERIFY_EN
  logic        verr [2];
`endif

  logic [15:0] ram [2] = '{16'h0000, 16'h0000};
  logic        res [2] = '{1'b0, 1'b0};

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ram16_burst_master #(.BURST_LEN(16)) dut16 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy[0]),
    .req_write(req_write), .req_wdata(req_wdata), .rsp_valid(rspv[0]), .rsp_rdata(rdata[0]),
    .mem_we(we[0]), .mem_set(set[0]), .mem_a0(a0[0]), .mem_a1(a1[0]), .mem_a2(a2[0]), .mem_a3(a3[0]),
`ifdef RAM16_WRITE_VERIFY_EN
    .verify_err(verr[0]),
`endif
    .mem_result(memRes[0])
  );

  ram16_burst_master #(.BURST_LEN(4)) dut4 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy[1]),
    .req_write(req_write), .req_wdata(req_wdata), .rsp_valid(rspv[1]), .rsp_rdata(rdata[1]),
    .mem_we(we[1]), .mem_set(set[1]), .mem_a0(a0[1]), .mem_a1(a1[1]), .mem_a2(a2[1]), .mem_a3(a3[1]),
`ifdef RAM16_WRITE_VERIFY_EN
    .verify_err(verr[1]),
`endif
    .mem_result(memRes[1])
  );

  function automatic int blOf(input int i);
    return (i == 0) ? 16 : 4;
  endfunction

  function automatic logic [15:0] maskOf(input int i);
    logic [15:0] m;
    m = 16'h0000;
    for (int k = 0; k < blOf(i); k++) m[k] = 1'b1;
    return m;
  endfunction

  function automatic logic [3:0] addrOf(input int i);
    return {a0[i], a1[i], a2[i], a3[i]};
  endfunction

  // ram16 model: registered result, echoes the set value during a write.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (we[i]) ram[i][addrOf(i)] <= set[i];
      res[i] <= we[i] ? set[i] : ram[i][addrOf(i)];
    end
  end

  assign memRes[0] = forceZero ? 1'b0 : res[0];
  assign memRes[1] = forceZero ? 1'b0 : res[1];

  task automatic checkOutput(input string nm, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Reference model: t counts cycles since the accept edge; the word-level memory updates at accept.
  int          t [2] = '{0, 0};
  logic        mw [2];
  logic [15:0] md [2];
  logic [15:0] pend [2];
  logic [15:0] expRd [2] = '{16'h0000, 16'h0000};
  logic        expErr [2] = '{1'b0, 1'b0};
  logic [15:0] refMem [2] = '{16'h0000, 16'h0000};

  always @(posedge clk or posedge reset) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        t[i]      = 0;
        expRd[i]  = 16'h0000;
        expErr[i] = 1'b0;
      end else if (t[i] == 0 || t[i] == blOf(i) + 2) begin
        if (req_valid) begin
          t[i]  = 1;
          mw[i] = req_write;
          md[i] = req_wdata;
          if (req_write) begin
            refMem[i] = (refMem[i] & ~maskOf(i)) | (req_wdata & maskOf(i));
            expErr[i] = forceZero && ((req_wdata & maskOf(i)) != 16'h0000);
          end else begin
            pend[i]   = refMem[i] & maskOf(i);
            expErr[i] = 1'b0;
          end
        end else begin
          t[i] = 0;
        end
      end else begin
        t[i]++;
        if (t[i] == blOf(i) + 2 && !mw[i]) expRd[i] = pend[i];
      end
    end
  end

  always @(negedge clk) begin
    int   bl;
    int   tt;
    logic xfer;
    logic drain;
    for (int i = 0; i < 2; i++) begin
      bl    = blOf(i);
      tt    = t[i];
      xfer  = (tt >= 1) && (tt <= bl);
      drain = (tt == bl + 1);
      checkOutput($sformatf("req_ready[%0d]", i), 16'(rdy[i]), 16'(!(xfer || drain)));
      checkOutput($sformatf("rsp_valid[%0d]", i), 16'(rspv[i]), 16'(tt == bl + 2));
      checkOutput($sformatf("mem_we[%0d]", i), 16'(we[i]), 16'(xfer && mw[i]));
      checkOutput($sformatf("addr[%0d]", i), 16'(addrOf(i)), xfer ? 16'(tt - 1) : (drain ? 16'(bl - 1) : 16'h0000));
      if (xfer) checkOutput($sformatf("mem_set[%0d]", i), 16'(set[i]), 16'(mw[i] & md[i][tt - 1]));
      checkOutput($sformatf("rsp_rdata[%0d]", i), rdata[i], expRd[i]);
`ifdef RAM16_WRITE_VERIFY_EN
      if (tt == bl + 2) checkOutput($sformatf("verify_err[%0d]", i), 16'(verr[i]), 16'(expErr[i]));
`endif
    end
  end

  // Presents a request and returns on the accept edge (plus 1) with the number of cycles waited.
  task automatic applyStimulus(input logic w, input logic [15:0] d, output int n);
    n = 0;
    do begin
      @(negedge clk);
      if (n == 0) begin
        req_valid = 1'b1;
        req_write = w;
        req_wdata = d;
      end
      n++;
    end while (!rdy[0] && n < 100);
    if (!rdy[0]) checkOutput("accept timeout", 16'(rdy[0]), 16'h0001);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic waitRsp(output int c0, output int c1);
    c0 = 0;
    c1 = 0;
    for (int n = 1; n <= 40 && c0 == 0; n++) begin
      @(negedge clk);
      if (rspv[0] && c0 == 0) c0 = n;
      if (rspv[1] && c1 == 0) c1 = n;
    end
  endtask

  initial begin
    int n, n2, c0, c1;
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    checkOutput("reset req_ready", 16'(rdy[0]), 16'h0001);
    checkOutput("reset rsp_valid", 16'(rspv[0]), 16'h0000);
    checkOutput("reset rsp_rdata", rdata[0], 16'h0000);

    applyStimulus(1'b1, 16'hFFFF, n);
    waitRsp(c0, c1);
    checkOutput("latency 16", 16'(c0), 16'd18);
    checkOutput("latency 4", 16'(c1), 16'd6);
    applyStimulus(1'b0, 16'h0000, n);
    waitRsp(c0, c1);
    checkOutput("read 16 after FFFF", rdata[0], 16'hFFFF);
    checkOutput("read 4 after FFFF", rdata[1], 16'h000F);

    applyStimulus(1'b1, 16'h3C3C, n);
    repeat (5) @(posedge clk);
    #2;
    checkOutput("mid xfer addr", 16'(addrOf(0)), 16'd5);
    checkOutput("mid xfer we", 16'(we[0]), 16'h0001);
    reset = 1'b1;
    #1;
    checkOutput("async reset we", 16'(we[0]), 16'h0000);
    checkOutput("async reset rsp_valid", 16'(rspv[0]), 16'h0000);
    checkOutput("async reset ready", 16'(rdy[0]), 16'h0001);
    checkOutput("async reset rdata", rdata[0], 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    refMem[0] = ram[0];
    refMem[1] = ram[1];

    applyStimulus(1'b1, 16'hA5C3, n);
    waitRsp(c0, c1);
    checkOutput("write A5C3 latency", 16'(c0), 16'd18);
    applyStimulus(1'b0, 16'h0000, n);
    waitRsp(c0, c1);
    checkOutput("read A5C3", rdata[0], 16'hA5C3);

    applyStimulus(1'b1, 16'hFFFF, n);
    applyStimulus(1'b1, 16'h0000, n2);
    checkOutput("back-to-back accept cycle", 16'(n2), 16'd18);
    waitRsp(c0, c1);
    applyStimulus(1'b0, 16'hFFFF, n);
    waitRsp(c0, c1);
    checkOutput("read after back-to-back", rdata[0], 16'h0000);

    applyStimulus(1'b1, 16'h1234, n);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      req_valid = 1'b1;
      req_write = 1'($urandom);
      req_wdata = 16'($urandom) | 16'h8000;
    end
    @(negedge clk);
    req_valid = 1'b0;
    applyStimulus(1'b0, 16'h0000, n);
    waitRsp(c0, c1);
    checkOutput("ignored request during xfer", rdata[0], 16'h1234);

`ifdef RAM16_WRITE_VERIFY_EN
    forceZero = 1'b1;
    applyStimulus(1'b1, 16'h0001, n);
    waitRsp(c0, c1);
    checkOutput("verify_err on forced echo", 16'(verr[0]), 16'h0001);
    forceZero = 1'b0;
    applyStimulus(1'b1, 16'h5AA5, n);
    waitRsp(c0, c1);
    checkOutput("verify_err after clean write", 16'(verr[0]), 16'h0000);
`endif

    repeat (40) begin
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        req_valid = 1'b0;
        req_wdata = 16'($urandom);
      end
      applyStimulus(1'($urandom), 16'($urandom), n);
    end
    waitRsp(c0, c1);
    repeat (8) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
